// File: rtl/jacobian_to_affine.sv
// jacobian_to_affine: converts a Jacobian point (X, Y, Z) over the secp256k1
// field to affine coordinates x = X*Z^-2, y = Y*Z^-3, with Z^-1 = Z^(P-2)
// evaluated by left-to-right square-and-multiply on one shared mod_mul.
// Optional feature macro: JAC2AFF_Z_ONE_BYPASS_EN (Z == 1 returns X, Y directly).

// mod_mul: result = a*b mod P, interleaved shift-add, DIGIT multiplier bits per cycle.
module mod_mul #(
  parameter int unsigned      WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter int unsigned      DIGIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  localparam int unsigned      STEPS = WIDTH / DIGIT;
  localparam int unsigned      CW    = $clog2(STEPS + 1);
  localparam logic [WIDTH+1:0] PX    = {2'b00, P};

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    cnt;
  logic             running;

  // Fold the next DIGIT multiplier bits (MSB first) into the partial product; 2r+a < 3P.
  always_comb begin
    logic [WIDTH+1:0] acc_w;
    acc_w = {2'b00, result};
    for (int unsigned j = 0; j < DIGIT; j++) begin
      acc_w = {acc_w[WIDTH:0], 1'b0} + (b_r[WIDTH-1-j] ? {2'b00, a_r} : '0);
      if (acc_w >= PX) acc_w = acc_w - PX;
      if (acc_w >= PX) acc_w = acc_w - PX;
    end
    r_next = acc_w[WIDTH-1:0];
  end

  // Operand capture and step counting; done pulses while result holds the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      result  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        a_r     <= a;
        b_r     <= b;
        result  <= '0;
        cnt     <= CW'(STEPS);
        running <= 1'b1;
      end else if (running) begin
        result <= r_next;
        b_r    <= b_r << DIGIT;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

module jacobian_to_affine #(
  parameter int unsigned      WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] x_aff,
  output logic [WIDTH-1:0] y_aff,
  output logic             inf,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] E  = P - WIDTH'(2);
  localparam int unsigned      IW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    IDLE, CHECK, SQ, MUL, NEXT, ZINV2, XMUL, ZINV3, YMUL, DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] xr, yr, zr, acc, t;
  logic [WIDTH-1:0] a, b, op_a, op_b, mul_result;
  logic [IW-1:0]    idx;
  logic             start_mul, mul_done, issued, mul_state;

  mod_mul #(.WIDTH(WIDTH), .P(P), .DIGIT(16)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .a      (a),
    .b      (b),
    .result (mul_result),
    .done   (mul_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and multiplier operand selection for the current step.
  always_comb begin
    state_next = state;
    op_a       = acc;
    op_b       = acc;
    mul_state  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = CHECK;
      CHECK: begin
        if (zr == '0) state_next = DONE;
        else          state_next = SQ;
`ifdef JAC2AFF_Z_ONE_BYPASS_EN
        if (zr == WIDTH'(1)) state_next = DONE;
`endif
      end
      SQ: begin
        mul_state = 1'b1;
        if (mul_done) state_next = E[idx] ? MUL : NEXT;
      end
      MUL: begin
        mul_state = 1'b1;
        op_b      = zr;
        if (mul_done) state_next = NEXT;
      end
      NEXT:  state_next = (idx == '0) ? ZINV2 : SQ;
      ZINV2: begin
        mul_state = 1'b1;
        if (mul_done) state_next = XMUL;
      end
      XMUL: begin
        mul_state = 1'b1;
        op_a      = xr;
        op_b      = t;
        if (mul_done) state_next = ZINV3;
      end
      ZINV3: begin
        mul_state = 1'b1;
        op_a      = t;
        op_b      = acc;
        if (mul_done) state_next = YMUL;
      end
      YMUL: begin
        mul_state = 1'b1;
        op_a      = yr;
        op_b      = t;
        if (mul_done) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: one multiply issued on entry to each multiply state, result consumed on mul_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      acc       <= '0;
      t         <= '0;
      a         <= '0;
      b         <= '0;
      idx       <= '0;
      start_mul <= 1'b0;
      issued    <= 1'b0;
      x_aff     <= '0;
      y_aff     <= '0;
      inf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_mul <= 1'b0;
      done      <= 1'b0;
      if (mul_state && !issued) begin
        a         <= op_a;
        b         <= op_b;
        start_mul <= 1'b1;
        issued    <= 1'b1;
      end
      if (mul_done) issued <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xr   <= X;
          yr   <= Y;
          zr   <= Z;
          busy <= 1'b1;
        end
        CHECK: begin
          if (zr == '0) begin
            inf   <= 1'b1;
            x_aff <= '0;
            y_aff <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc <= zr;
            idx <= IW'(WIDTH - 2);
          end
`ifdef JAC2AFF_Z_ONE_BYPASS_EN
          if (zr == WIDTH'(1)) begin
            x_aff <= xr;
            y_aff <= yr;
            inf   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
`endif
        end
        SQ, MUL:      if (mul_done) acc <= mul_result;
        NEXT:         if (idx != '0) idx <= idx - IW'(1);
        ZINV2, ZINV3: if (mul_done) t <= mul_result;
        XMUL:         if (mul_done) x_aff <= mul_result;
        YMUL: if (mul_done) begin
          y_aff <= mul_result;
          inf   <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
